// File: rtl/ps2_pkg.sv
// PS/2 host transmitter: shared states, default timing and counter widths.
// Timing defaults assume a 50 MHz clock.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      BITS,
      ACK,
      WAIT_IDLE
   } state_e;

   localparam int INHIBIT_CYC_DEF = 6000;
   localparam int START_TMO_DEF   = 750000;
   localparam int PKT_TMO_DEF     = 100000;
   localparam int FILT_LEN_DEF    = 4;
   localparam int REQ_CYC         = 20;
   localparam int TMR_W           = 20;
   localparam int BCNT_W          = 4;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, filters glitches, and flags falling edges.
// A level is accepted only after FILT_LEN identical synchronized samples.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   logic [1:0]          sync_q;
   logic [FILT_LEN-1:0] hist_q;
   logic [FILT_LEN-1:0] hist_d;
   logic                filt_q;
   logic                filt_d;

   always_comb begin
      hist_d = {hist_q[FILT_LEN-2:0], sync_q[1]};
      filt_d = filt_q;
      if (&hist_q) begin
         filt_d = 1'b1;
      end else if (~|hist_q) begin
         filt_d = 1'b0;
      end
   end

   // Idle PS/2 lines are high, so everything presets to 1
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
         hist_q <= '1;
         filt_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], line_i};
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign level_o = filt_q;
   assign fall_o  = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter with open-drain enables,
// inhibit/request sequencing, ack check and start/packet timeouts.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
   parameter int START_TMO   = START_TMO_DEF,
   parameter int PKT_TMO     = PKT_TMO_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF
) (
   input  logic       clock50,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   state_e              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [8:0]          sh_q, sh_d;
   logic                clk_oe_q, clk_oe_d;
   logic                dat_oe_q, dat_oe_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                clk_lvl, clk_fall;
   logic                dat_lvl, dat_fall;
   logic [TMR_W-1:0]    tmo_lim;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_i   (clock50),
      .rst_ni  (reset_n),
      .line_i  (ps2_clk_i),
      .level_o (clk_lvl),
      .fall_o  (clk_fall)
   );

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
      .clk_i   (clock50),
      .rst_ni  (reset_n),
      .line_i  (ps2_dat_i),
      .level_o (dat_lvl),
      .fall_o  (dat_fall)
   );

   assign tmo_lim = (bcnt_q == '0) ? TMR_W'(START_TMO)
                                   : TMR_W'(PKT_TMO);

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bcnt_d   = bcnt_q;
      sh_d     = sh_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            tmr_d    = '0;
            bcnt_d   = '0;
            if (tx_start && !done_q && !err_q) begin
               sh_d     = {~^tx_data, tx_data};
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_q == TMR_W'(INHIBIT_CYC - 1)) begin
               dat_oe_d = 1'b1;
               tmr_d    = '0;
               state_d  = REQ;
            end
         end
         REQ: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_q == TMR_W'(REQ_CYC - 1)) begin
               clk_oe_d = 1'b0;
               tmr_d    = '0;
               state_d  = BITS;
            end
         end
         BITS, ACK, WAIT_IDLE: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_q == tmo_lim) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               err_d    = 1'b1;
               state_d  = IDLE;
            end else if (state_q == BITS && clk_fall) begin
               // 1s shifted in behind parity make edge 10 release data
               bcnt_d   = bcnt_q + BCNT_W'(1);
               dat_oe_d = ~sh_q[0];
               sh_d     = {1'b1, sh_q[8:1]};
               if (bcnt_q == '0) tmr_d = '0;
               if (bcnt_q == BCNT_W'(9)) state_d = ACK;
            end else if (state_q == ACK && clk_fall) begin
               bcnt_d = bcnt_q + BCNT_W'(1);
               if (dat_lvl) begin
                  dat_oe_d = 1'b0;
                  err_d    = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = WAIT_IDLE;
               end
            end else if (state_q == WAIT_IDLE && clk_lvl && dat_lvl) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         tmr_q    <= '0;
         bcnt_q   <= '0;
         sh_q     <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         bcnt_q   <= bcnt_d;
         sh_q     <= sh_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign tx_busy    = (state_q != IDLE);
   assign tx_done    = done_q;
   assign tx_error   = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a behavioural PS/2 device
// that clocks the frame in and compares it with a model frame.
module tb_ps2_tx;

   localparam int INH  = 50;
   localparam int STMO = 300;
   localparam int PTMO = 2000;

   logic       clock50 = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       clk_line, dat_line;

   int n_vec = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   assign clk_line = ~(ps2_clk_oe | dev_clk_low);
   assign dat_line = ~(ps2_dat_oe | dev_dat_low);

   ps2_tx #(
      .INHIBIT_CYC (INH),
      .START_TMO   (STMO),
      .PKT_TMO     (PTMO),
      .FILT_LEN    (4)
   ) dut (
      .clock50    (clock50),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_i  (clk_line),
      .ps2_dat_i  (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #10 clock50 = ~clock50;

   always @(posedge clock50) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Expected line bits: start, 8 data LSB first, odd parity, stop
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         ones += int'(d[i]);
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   always @(negedge clock50) begin
      if (reset_n && (tx_done || tx_error)) begin
         chk("pulse_excl", 32'(tx_done & tx_error), 32'd0);
         chk("busy_at_pulse", 32'(tx_busy), 32'd0);
         if (tx_error)
            chk("oe_at_err", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
         if (tx_done) done_cnt <= done_cnt + 1;
         if (tx_error) err_cnt <= err_cnt + 1;
      end
   end

   task automatic start_pulse(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock50);
      tx_start = 1'b0;
   endtask

   task automatic dev_rx(input bit ack, input int h, input bit glt,
                         input int stop_at, output logic [10:0] fr,
                         output bit ok);
      int n;
      ok = 1'b0;
      fr = '0;
      n  = 0;
      while (!(clk_line && !dat_line) && n < 5000) begin
         @(negedge clock50);
         n++;
      end
      if (n >= 5000) return;
      repeat (h) @(negedge clock50);
      fr[0] = dat_line;
      for (int i = 1; i <= 11; i++) begin
         dev_clk_low = 1'b1;
         for (int k = 0; k < h; k++) begin
            if (glt && k == h / 2 && i >= 2 && i <= 9) begin
               dev_clk_low = 1'b0;
               @(negedge clock50);
               dev_clk_low = 1'b1;
            end
            @(negedge clock50);
         end
         if (i == stop_at) begin
            ok = 1'b1;
            return;
         end
         dev_clk_low = 1'b0;
         if (i <= 10) fr[i] = dat_line;
         if (i == 11) begin
            dev_dat_low = 1'b0;
            ok = 1'b1;
            return;
         end
         if (glt && i == 5) begin
            tx_data  = 8'($urandom);
            tx_start = 1'b1;
            @(negedge clock50);
            tx_start = 1'b0;
         end
         for (int k = 0; k < h; k++) begin
            if (i == 10 && ack && k == h / 2) dev_dat_low = 1'b1;
            if (glt && k == h / 2 && i >= 2 && i <= 9) begin
               dev_clk_low = 1'b1;
               @(negedge clock50);
               dev_clk_low = 1'b0;
            end
            @(negedge clock50);
         end
      end
   endtask

   task automatic wait_end(input int d0, input int e0, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (tx_done || tx_error || done_cnt != d0 || err_cnt != e0) begin
            hit = 1'b1;
            return;
         end
         @(negedge clock50);
      end
   endtask

   task automatic xfer(input logic [7:0] d, input bit ack, input bit glt);
      int d0, e0;
      logic [10:0] fr;
      bit ok, hit;
      d0 = done_cnt;
      e0 = err_cnt;
      start_pulse(d);
      chk("busy_after_start", 32'(tx_busy), 32'd1);
      dev_rx(ack, $urandom_range(20, 40), glt, 0, fr, ok);
      chk("dev_req", 32'(ok), 32'd1);
      wait_end(d0, e0, hit);
      chk("end_seen", 32'(hit), 32'd1);
      repeat (3) @(negedge clock50);
      chk("frame", 32'(fr), 32'(model_frame(d)));
      chk("done_cnt", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
      chk("err_cnt", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
      chk("lines_rel", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      chk("busy_end", 32'(tx_busy), 32'd0);
   endtask

   initial begin
      int d0, e0, n, r;
      logic [10:0] fr;
      bit ok, hit;

      repeat (3) @(negedge clock50);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_err", 32'(tx_error), 32'd0);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      reset_n = 1'b1;

      xfer(8'hED, 1'b1, 1'b0);

      d0 = done_cnt;
      e0 = err_cnt;
      start_pulse(8'h01);
      dev_rx(1'b1, 25, 1'b0, 0, fr, ok);
      chk("chain_req1", 32'(ok), 32'd1);
      wait_end(d0, e0, hit);
      chk("chain_done_now", 32'(tx_done), 32'd1);
      tx_data  = 8'hFF;
      tx_start = 1'b1;
      @(negedge clock50);
      chk("start_on_done_ign", 32'(tx_busy), 32'd0);
      @(negedge clock50);
      chk("start_next_acc", 32'(tx_busy), 32'd1);
      tx_start = 1'b0;
      chk("chain_frame1", 32'(fr), 32'(model_frame(8'h01)));
      chk("chain_done1", 32'(done_cnt - d0), 32'd1);
      d0 = done_cnt;
      dev_rx(1'b1, 30, 1'b0, 0, fr, ok);
      chk("chain_req2", 32'(ok), 32'd1);
      wait_end(d0, e0, hit);
      repeat (3) @(negedge clock50);
      chk("chain_frame2", 32'(fr), 32'(model_frame(8'hFF)));
      chk("chain_done2", 32'(done_cnt - d0), 32'd1);
      chk("chain_err", 32'(err_cnt - e0), 32'd0);

      start_pulse(8'h55);
      n = 0;
      while (ps2_clk_oe && n < 200) begin
         @(negedge clock50);
         n++;
      end
      chk("tmo_release", 32'(ps2_clk_oe), 32'd0);
      r = cyc;
      n = 0;
      while (!tx_error && n < 1000) begin
         @(negedge clock50);
         n++;
      end
      chk("tmo_cycles", 32'(cyc - r), 32'(STMO + 1));
      chk("tmo_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      repeat (3) @(negedge clock50);

      xfer(8'h3C, 1'b0, 1'b0);

      start_pulse(8'hA7);
      dev_rx(1'b1, 30, 1'b0, 5, fr, ok);
      chk("rst_mid_req", 32'(ok), 32'd1);
      chk("dat_oe_pre_rst", 32'(ps2_dat_oe), 32'd1);
      chk("busy_pre_rst", 32'(tx_busy), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("async_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("async_busy", 32'(tx_busy), 32'd0);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(negedge clock50);
      reset_n = 1'b1;
      repeat (2) @(negedge clock50);
      xfer(8'hF4, 1'b1, 1'b0);

      xfer(8'($urandom), 1'b1, 1'b1);

      for (int t = 0; t < 4; t++)
         xfer(8'($urandom), $urandom_range(0, 3) != 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 6000, clock low-hold before the start bit (120 us at 50 MHz).
REQ-002 Parameter START_TMO, default 750000, maximum wait from clock release to the first device falling edge (15 ms).
REQ-003 Parameter PKT_TMO, default 100000, maximum time from the first falling edge to the ack (2 ms).
REQ-004 Parameter FILT_LEN, default 4, consecutive equal samples needed before a line level is accepted.
REQ-005 clock50  in  1  sole clock, 50 MHz; everything is synchronous to its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 tx_data  in  8  byte to send; captured when tx_start is accepted.
REQ-008 tx_start  in  1  one-cycle request; accepted only in IDLE and ignored otherwise.
REQ-009 tx_busy  out  1  high from the accept cycle until tx_done or tx_error.
REQ-010 tx_done  out  1  one-cycle pulse on acknowledged completion.
REQ-011 tx_error  out  1  one-cycle pulse on timeout or missing ack.
REQ-012 ps2_clk_i, ps2_dat_i  in  1 each  raw PS/2 line levels (asynchronous).
REQ-013 ps2_clk_oe, ps2_dat_oe  out  1 each  1 = pull the line low; 0 = release it (top level drives 1'b0 or 1'bz).

Function
REQ-014 Both input lines SHALL pass a 2-flop synchronizer, then a FILT_LEN glitch filter; device clock falling edges are detected on the filtered clock only.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE.
REQ-016 Transitions SHALL be:
- IDLE + tx_start: latch tx_data, compute odd parity (~^tx_data), go to INHIBIT, ps2_clk_oe=1.
- INHIBIT: after INHIBIT_CYC cycles set ps2_dat_oe=1, go to REQ.
- REQ: after 20 cycles set ps2_clk_oe=0, clear the timer, go to BITS.
- BITS: on falling edges 1..8 drive data bits 0..7 (LSB first) with ps2_dat_oe=~bit; edge 9 drives parity; edge 10 releases data (stop), then go to ACK.
- ACK: on falling edge 11 sample filtered data; 0 goes to WAIT_IDLE, 1 is an error.
- WAIT_IDLE: once filtered clk and dat are both 1, pulse tx_done and go to IDLE.
REQ-017 A 20-bit timer SHALL run in REQ-release/BITS/ACK/WAIT_IDLE:
- START_TMO applies before edge 1.
- PKT_TMO applies after edge 1.
- On expiry: release both lines, pulse tx_error, go to IDLE.
REQ-018 A bit counter SHALL count 0..11 and never wrap; extra edges in WAIT_IDLE are ignored.
REQ-019 On any error both oe outputs SHALL be 0 in the same cycle tx_error is asserted.
REQ-020 tx_done and tx_error SHALL never assert together; tx_busy SHALL fall in the cycle either pulse is high.
REQ-021 A tx_start coinciding with a tx_done/tx_error pulse SHALL be ignored; a new start is accepted from the next cycle.
REQ-022 In IDLE both oe outputs SHALL be 0, so the device may transmit to the existing receiver.

Reset
REQ-023 While reset_n=0, all outputs SHALL be 0, the state IDLE, the timer and counter 0, and the filters preset to 1; this takes effect asynchronously, including mid-transfer.
REQ-024 After reset release, the first tx_start SHALL be accepted on the next clock edge.

Structure
REQ-025 Package ps2_pkg SHALL hold the state enum, the default timing constants, and the bit-count width.
REQ-026 One sub-module, ps2_line_filter (synchronizer, filter, falling-edge output), SHALL be instantiated for clk and for dat.
REQ-027 Implementation SHALL be 120-400 lines of RTL with no tristates inside the block.

Verification
REQ-028 Device model at 80 us clock period, tx_data=0xED -> bits sampled on rising edges are 0,1,0,1,1,0,1,1,1,p=1,stop=1; model acks -> one tx_done, no tx_error.
REQ-029 tx_data=0x01 then 0xFF, back-to-back starts after done -> parity 0 then 1; both complete; the 2nd start is accepted only after the 1st tx_done.
REQ-030 Device never clocks -> tx_error exactly START_TMO+1 cycles after clock release; both oe=0.
REQ-031 Model leaves data high at edge 11 -> tx_error, no tx_done; lines released.
REQ-032 reset_n pulled low after edge 5 -> oe outputs 0 asynchronously; tx_busy=0; the next 0xF4 transfer is correct.
REQ-033 1-cycle glitches on ps2_clk_i during BITS -> no extra bit advance; tx_start pulsed while busy -> ignored.
